// File: rtl/common_pkg.sv
// Shared types and constants for the register scoreboard: per-register entry
// layout, readiness thresholds and small helpers used by the bank and the top.
package common_pkg;

    localparam int         NUM_REGS          = 32;
    localparam logic [1:0] ALU_READY_AGE     = 2'd1;
    localparam logic [1:0] LOAD_READY_AGE    = 2'd2;
    localparam logic [1:0] LONG_DONE_AGE     = 2'd2;
    localparam logic [1:0] AGE_MAX           = 2'd3;
    localparam int         MAX_LONG_INFLIGHT = 1;

    typedef struct packed {
        logic       pending;
        logic       long_op;
        logic       is_load;
        logic [1:0] age;
    } sb_entry_t;

    // Readiness is judged for the cycle the consumer in ID reaches EX, one cycle ahead.
    function automatic logic entry_busy(sb_entry_t e);
        logic [2:0] age_next;
        logic [2:0] need;
        age_next = {1'b0, e.age} + 3'd1;
        need     = {1'b0, (e.is_load ? LOAD_READY_AGE : ALU_READY_AGE)};
        return e.pending && (e.long_op || (age_next < need));
    endfunction

    function automatic logic [6:0] popcount32(logic [31:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue/operand/writeback/completion bundle between the pipeline and the scoreboard.
interface reg_scoreboard_if;
    logic       issue_valid;
    logic [4:0] issue_rd;
    logic       issue_rd_float;
    logic       issue_load;
    logic       issue_long;
    logic [4:0] rs_1;
    logic [4:0] rs_2;
    logic       rs_1_used;
    logic       rs_2_used;
    logic       reg_read_float;
    logic       long_done;
    logic [4:0] long_rd;
    logic       long_rd_float;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       wb_float;
    logic       flush;
    logic       stall;
    logic [6:0] pending_count;

    modport master (
        output issue_valid, issue_rd, issue_rd_float, issue_load, issue_long,
        output rs_1, rs_2, rs_1_used, rs_2_used, reg_read_float,
        output long_done, long_rd, long_rd_float,
        output wb_valid, wb_rd, wb_float, flush,
        input  stall, pending_count
    );

    modport slave (
        input  issue_valid, issue_rd, issue_rd_float, issue_load, issue_long,
        input  rs_1, rs_2, rs_1_used, rs_2_used, reg_read_float,
        input  long_done, long_rd, long_rd_float,
        input  wb_valid, wb_rd, wb_float, flush,
        output stall, pending_count
    );
endinterface

// File: rtl/sb_bank.sv
// One register file's worth of scoreboard entries: set on issue, clear on
// writeback, long-op completion, aging, and busy lookups for the hazard logic.
module sb_bank
    import common_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_set,
    input  logic [4:0]  i_set_idx,
    input  logic        i_set_long,
    input  logic        i_set_load,
    input  logic        i_clr,
    input  logic [4:0]  i_clr_idx,
    input  logic        i_done,
    input  logic [4:0]  i_done_idx,
    input  logic [4:0]  i_rs1_idx,
    input  logic [4:0]  i_rs2_idx,
    input  logic [4:0]  i_waw_idx,
    output logic        o_rs1_busy,
    output logic        o_rs2_busy,
    output logic        o_waw_busy,
    output logic [31:0] o_long_vec,
    output logic [31:0] o_pend_next
);

    sb_entry_t [NUM_REGS-1:0] r_ent;
    sb_entry_t [NUM_REGS-1:0] w_nxt;

    // Priority per entry, lowest first: aging, completion, writeback clear, new issue.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_nxt[i] = r_ent[i];
            if (r_ent[i].pending && !r_ent[i].long_op && (r_ent[i].age != AGE_MAX)) begin
                w_nxt[i].age = r_ent[i].age + 2'd1;
            end
            if (i_done && (i_done_idx == 5'(i)) && r_ent[i].pending && r_ent[i].long_op) begin
                w_nxt[i].long_op = 1'b0;
                w_nxt[i].age     = LONG_DONE_AGE;
            end
            if (i_clr && (i_clr_idx == 5'(i))) begin
                w_nxt[i] = '0;
            end
            if (i_set && (i_set_idx == 5'(i))) begin
                w_nxt[i].pending = 1'b1;
                w_nxt[i].long_op = i_set_long;
                w_nxt[i].is_load = i_set_load;
                w_nxt[i].age     = 2'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ent <= '0;
        end else begin
            r_ent <= w_nxt;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            o_long_vec[i]  = r_ent[i].pending && r_ent[i].long_op;
            o_pend_next[i] = w_nxt[i].pending;
        end
    end

    assign o_rs1_busy = entry_busy(r_ent[i_rs1_idx]);
    assign o_rs2_busy = entry_busy(r_ent[i_rs2_idx]);
    assign o_waw_busy = r_ent[i_waw_idx].pending && r_ent[i_waw_idx].long_op;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard top: integer and float banks, combinational stall
// (RAW, WAW against a long op, long-unit occupancy) and registered pending count.
module reg_scoreboard
    import common_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    reg_scoreboard_if.slave  sb
);

    logic        w_accept;
    logic        w_int_set;
    logic        w_flt_set;
    logic        w_i_rs1_busy, w_i_rs2_busy, w_i_waw_busy;
    logic        w_f_rs1_busy, w_f_rs2_busy, w_f_waw_busy;
    logic [31:0] w_i_long, w_f_long;
    logic [31:0] w_i_pend_next, w_f_pend_next;
    logic        w_rs1_x0, w_rs2_x0;
    logic        w_rs1_busy, w_rs2_busy;
    logic        w_raw, w_waw, w_long_full;
    logic [6:0]  w_long_cnt;
    logic        w_stall;
    logic [6:0]  r_pending_count;

    assign w_accept  = sb.issue_valid && !w_stall && !sb.flush;
    // x0 is hardwired, so an issue targeting it never creates an entry.
    assign w_int_set = w_accept && !sb.issue_rd_float && (sb.issue_rd != 5'd0);
    assign w_flt_set = w_accept && sb.issue_rd_float;

    sb_bank u_int_bank (
        .clk         (clk),
        .rst         (rst),
        .i_set       (w_int_set),
        .i_set_idx   (sb.issue_rd),
        .i_set_long  (sb.issue_long),
        .i_set_load  (sb.issue_load),
        .i_clr       (sb.wb_valid && !sb.wb_float),
        .i_clr_idx   (sb.wb_rd),
        .i_done      (sb.long_done && !sb.long_rd_float),
        .i_done_idx  (sb.long_rd),
        .i_rs1_idx   (sb.rs_1),
        .i_rs2_idx   (sb.rs_2),
        .i_waw_idx   (sb.issue_rd),
        .o_rs1_busy  (w_i_rs1_busy),
        .o_rs2_busy  (w_i_rs2_busy),
        .o_waw_busy  (w_i_waw_busy),
        .o_long_vec  (w_i_long),
        .o_pend_next (w_i_pend_next)
    );

    sb_bank u_flt_bank (
        .clk         (clk),
        .rst         (rst),
        .i_set       (w_flt_set),
        .i_set_idx   (sb.issue_rd),
        .i_set_long  (sb.issue_long),
        .i_set_load  (sb.issue_load),
        .i_clr       (sb.wb_valid && sb.wb_float),
        .i_clr_idx   (sb.wb_rd),
        .i_done      (sb.long_done && sb.long_rd_float),
        .i_done_idx  (sb.long_rd),
        .i_rs1_idx   (sb.rs_1),
        .i_rs2_idx   (sb.rs_2),
        .i_waw_idx   (sb.issue_rd),
        .o_rs1_busy  (w_f_rs1_busy),
        .o_rs2_busy  (w_f_rs2_busy),
        .o_waw_busy  (w_f_waw_busy),
        .o_long_vec  (w_f_long),
        .o_pend_next (w_f_pend_next)
    );

    assign w_rs1_x0   = !sb.reg_read_float && (sb.rs_1 == 5'd0);
    assign w_rs2_x0   = !sb.reg_read_float && (sb.rs_2 == 5'd0);
    assign w_rs1_busy = sb.reg_read_float ? w_f_rs1_busy : w_i_rs1_busy;
    assign w_rs2_busy = sb.reg_read_float ? w_f_rs2_busy : w_i_rs2_busy;
    assign w_raw      = (sb.rs_1_used && !w_rs1_x0 && w_rs1_busy) ||
                        (sb.rs_2_used && !w_rs2_x0 && w_rs2_busy);
    assign w_waw      = sb.issue_valid && (sb.issue_rd_float ? w_f_waw_busy : w_i_waw_busy);
    assign w_long_cnt = popcount32(w_i_long) + popcount32(w_f_long);
    assign w_long_full = sb.issue_valid && sb.issue_long &&
                         (w_long_cnt >= 7'(MAX_LONG_INFLIGHT));
    assign w_stall    = !rst && (w_raw || w_waw || w_long_full);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending_count <= '0;
        end else begin
            r_pending_count <= popcount32(w_i_pend_next) + popcount32(w_f_pend_next);
        end
    end

    assign sb.stall         = w_stall;
    assign sb.pending_count = r_pending_count;

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have ports (name  direction  width  meaning), clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  instruction leaving ID into EX this cycle.
- issue_rd  in  5  destination register.
- issue_rd_float  in  1  destination is in the float register file.
- issue_load  in  1  instruction is a load; result available in WB.
- issue_long  in  1  multi-cycle op (e.g. float div); result available only at completion.
- rs_1  in  5  source 1 of the instruction in ID.
- rs_2  in  5  source 2 of the instruction in ID.
- rs_1_used  in  1  source 1 is read.
- rs_2_used  in  1  source 2 is read.
- reg_read_float  in  1  both sources read the float file.
- long_done  in  1  multi-cycle unit result is on the forwarding path this cycle.
- long_rd  in  5  destination of the completing long op.
- long_rd_float  in  1  register file of the completing long op.
- wb_valid  in  1  register-file write this cycle.
- wb_rd  in  5  register written.
- wb_float  in  1  register file of the write.
- flush  in  1  squash the instruction in ID.
- stall  out  1  hold ID and do not issue.
- pending_count  out  7  number of pending entries over both files.

Function
REQ-002 SHALL hold 32 integer and 32 float entries, each with pending (1b), long (1b) and age (2b, saturating at 3).
REQ-003 SHALL set an entry on an accepted issue (issue_valid && !stall && !flush): pending=1, long=issue_long, age=0, kind recorded as load or ALU.
REQ-004 SHALL never set integer x0; float f0 is an ordinary register.
REQ-005 SHALL increment the age of every pending, non-long entry by 1 per cycle, saturating at 3.
REQ-006 SHALL deem an entry ready when any of these holds:
- ALU: age>=1 (result in MEM).
- Load: age>=2 (result in WB).
- Long: long_done seen for it, which clears long and sets age=2.
REQ-007 SHALL clear pending on wb_valid for (wb_rd, wb_float).
REQ-008 SHALL let the new set win when an accepted issue and a wb_valid hit the same entry in the same cycle.
REQ-009 SHALL assert stall combinationally, same cycle, when either condition holds:
- RAW: a used source (selected by reg_read_float) is pending and not ready.
- WAW: issue_valid, the issue_rd entry is pending with long=1, and it is not done.
REQ-010 SHALL let a used source of x0 never cause a stall.
REQ-011 SHALL treat a single long op in flight as the unit limit; issue_long while any long entry is pending SHALL stall.
REQ-012 SHALL drop the same-cycle issue when flush=1; older entries SHALL be unaffected.
REQ-013 SHALL drive pending_count as a registered value equal to the population count of pending bits after the edge.

Reset
REQ-014 SHALL, on rst=1 and asynchronously, clear all pending, long and age fields.
REQ-015 SHALL hold stall=0 and pending_count=0 while rst=1.
REQ-016 SHALL drop a long op in flight when reset is asserted mid-operation; a later long_done SHALL be ignored unless its entry is pending and long.

Structure
REQ-017 SHALL place the sb_entry_t typedef and the constants ALU_READY_AGE=1, LOAD_READY_AGE=2 and MAX_LONG_INFLIGHT=1 in common_pkg.
REQ-018 SHALL use one sub-module, sb_bank (32 entries with set, clear, done and ready lookup), instantiated twice (integer, float), with stall and count logic in the top.

Verification
REQ-019 SHALL cover ALU RAW: issue add x5; next cycle rs_1=5 -> stall=0.
REQ-020 SHALL cover load-use: issue load x6 at cycle t; rs_2=6 at t+1 -> stall=1; at t+2 -> stall=0.
REQ-021 SHALL cover the long op path:
- Issue fdiv f3 (long); fadd reading f3 -> stall=1 until the cycle after long_done with long_rd=3, long_rd_float=1.
- A second issue_long during that window -> stall=1.
REQ-022 SHALL cover x0 and flush:
- Issue with rd=0, then rs_1=0 -> stall=0 and pending_count unchanged.
- issue_valid=1 with flush=1 -> no entry set, pending_count unchanged.
REQ-023 SHALL cover same-cycle set/clear and reset:
- wb_valid for x7 together with an accepted issue of x7 -> x7 stays pending, pending_count unchanged.
- rst pulsed with 4 entries pending -> pending_count=0 and stall=0 immediately.
